inj_scheduler: RTL and testbench

INJ_SCHEDULER -- requirements
Module: inj_scheduler

---
 rtl/inj_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_inj_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inj_scheduler.sv
// Round-robin injection sequencer: primes/drains NUM_SRC one-shot buffers into a skid FIFO.
// Optional stall counter output enabled by defining INJ_SCHED_STATS_EN.
module inj_scheduler #(
    parameter int NUM_SRC       = 4,
    parameter int WORDS_PER_SRC = 30,
    parameter int QUANTUM       = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [NUM_SRC-1:0]    buf_en,
    input  logic [20*NUM_SRC-1:0] buf_data,
    input  logic [NUM_SRC-1:0]    buf_valid,
    output logic [19:0]           inj_data,
    output logic                  inj_valid,
    input  logic                  inj_ready,
    output logic                  busy,
    output logic                  all_done,
`ifdef INJ_SCHED_STATS_EN
    output logic [15:0]           stall_cycles,
`endif
    output logic                  protocol_err
);

    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CW = $clog2(WORDS_PER_SRC + 1);
    localparam int QW = $clog2(QUANTUM + 1);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0] WMAX    = CW'(WORDS_PER_SRC);
    localparam logic [QW-1:0] QMAX    = QW'(QUANTUM);
    localparam logic [NW:0]   DEPTH_C = (NW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]   NSRC_C  = (PW+1)'(NUM_SRC);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      prev_ptr_q, prev_ptr_d;
    logic               inflight_q, inflight_d;
    logic [QW-1:0]      quant_q, quant_d;
    logic [NUM_SRC-1:0] primed_q, primed_d;
    logic [CW-1:0]      issued_q [NUM_SRC];
    logic [CW-1:0]      issued_d [NUM_SRC];
    logic               perr_q;

    logic [19:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_q, rd_q;
    logic [NW-1:0]      cnt_q;

    logic [NUM_SRC-1:0] ok_mask;
    logic               push, pop, bad, credit, found;
    logic [19:0]        push_data;
    logic [NW:0]        occ;
    logic [QW-1:0]      q_inc;
    logic [CW-1:0]      i_inc;
    logic [PW:0]        sum_w;
    logic [PW-1:0]      cand, nxt;

    // Only the source issued to last cycle may present a word now.
    assign ok_mask = inflight_q ? (NUM_SRC'(1) << prev_ptr_q) : '0;
    assign push    = |(buf_valid & ok_mask);
    assign bad     = |(buf_valid & ~ok_mask);

    always_comb begin
        push_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (prev_ptr_q == PW'(i)) push_data = buf_data[20*i +: 20];
        end
    end

    assign inj_valid = (cnt_q != '0);
    assign inj_data  = inj_valid ? mem_q[rd_q] : '0;
    assign pop       = inj_valid & inj_ready;
    assign occ       = (NW+1)'(cnt_q) + (NW+1)'(inflight_q);
    assign credit    = (occ < DEPTH_C);
    assign q_inc     = quant_q + 1'b1;
    assign i_inc     = issued_q[ptr_q] + 1'b1;

    assign busy         = (state_q == S_GRANT) || (state_q == S_DRAIN);
    assign all_done     = (state_q == S_DONE);
    assign protocol_err = perr_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        prev_ptr_d = ptr_q;
        inflight_d = 1'b0;
        quant_d    = quant_q;
        primed_d   = primed_q;
        issued_d   = issued_q;
        buf_en     = '0;
        found      = 1'b0;
        nxt        = ptr_q;
        sum_w      = '0;
        cand       = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_GRANT;
                    ptr_d    = '0;
                    quant_d  = '0;
                    primed_d = '0;
                    for (int i = 0; i < NUM_SRC; i++) issued_d[i] = '0;
                end
            end
            S_GRANT: begin
                if (credit) begin
                    buf_en = NUM_SRC'(1) << ptr_q;
                    if (!primed_q[ptr_q]) begin
                        primed_d[ptr_q] = 1'b1;
                    end else begin
                        inflight_d      = 1'b1;
                        issued_d[ptr_q] = i_inc;
                        quant_d         = q_inc;
                        if (q_inc == QMAX || i_inc == WMAX) begin
                            quant_d = '0;
                            // Scan forward, wrapping back to the current source last.
                            for (int k = 1; k <= NUM_SRC; k++) begin
                                sum_w = (PW+1)'(ptr_q) + (PW+1)'(k);
                                if (sum_w >= NSRC_C) sum_w = sum_w - NSRC_C;
                                cand = sum_w[PW-1:0];
                                if (!found && issued_d[cand] < WMAX) begin
                                    found = 1'b1;
                                    nxt   = cand;
                                end
                            end
                            if (found) ptr_d = nxt;
                            else       state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0 && !inflight_q) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            prev_ptr_q <= '0;
            inflight_q <= 1'b0;
            quant_q    <= '0;
            primed_q   <= '0;
            perr_q     <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < NUM_SRC; i++) issued_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            prev_ptr_q <= prev_ptr_d;
            inflight_q <= inflight_d;
            quant_q    <= quant_d;
            primed_q   <= primed_d;
            issued_q   <= issued_d;
            if (bad) perr_q <= 1'b1;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + NW'(push) - NW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= push_data;
    end

`ifdef INJ_SCHED_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            stall_q <= '0;
        end else if (busy && inj_valid && !inj_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_inj_scheduler.sv
// Scoreboard bench for inj_scheduler with behavioural one-shot buffer models.
// Define INJ_SCHED_STATS_EN to also check the stall counter.
module tb_inj_scheduler;

    localparam int NS = 4;
    localparam int W  = 30;
    localparam int Q  = 4;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NS-1:0] buf_en;
    logic [20*NS-1:0] buf_data;
    logic [NS-1:0] buf_valid;
    logic [19:0]   inj_data;
    logic          inj_valid;
    logic          inj_ready;
    logic          busy;
    logic          all_done;
    logic          protocol_err;
`ifdef INJ_SCHED_STATS_EN
    logic [15:0]   stall_cycles;
`endif

    inj_scheduler #(
        .NUM_SRC(NS), .WORDS_PER_SRC(W), .QUANTUM(Q), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .buf_en(buf_en),
        .buf_data(buf_data),
        .buf_valid(buf_valid),
        .inj_data(inj_data),
        .inj_valid(inj_valid),
        .inj_ready(inj_ready),
        .busy(busy),
        .all_done(all_done),
`ifdef INJ_SCHED_STATS_EN
        .stall_cycles(stall_cycles),
`endif
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int acc = 0;
    int delivered = 0;
    int stall_ref = 0;
    int rmode = 0;
    logic [7:0]    salt = 8'h00;
    logic [NS-1:0] spur = '0;
    logic          hold_v = 1'b0;
    logic [19:0]   hold_d = '0;
    logic [19:0]   exp_w;
    logic [19:0]   exp_q [$];

    // One-shot buffer: first enable primes, each later enable yields a word next cycle.
    logic [NS-1:0] bm_primed, bm_valid;
    logic [19:0]   bm_data [NS];
    int            bm_cnt [NS];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bm_primed <= '0;
            bm_valid  <= '0;
            for (int i = 0; i < NS; i++) begin
                bm_data[i] <= '0;
                bm_cnt[i]  <= 0;
            end
        end else begin
            for (int i = 0; i < NS; i++) begin
                bm_valid[i] <= 1'b0;
                if (buf_en[i]) begin
                    if (!bm_primed[i]) begin
                        bm_primed[i] <= 1'b1;
                    end else if (bm_cnt[i] < W) begin
                        bm_valid[i] <= 1'b1;
                        bm_data[i]  <= {salt, 4'(i), 8'(bm_cnt[i])};
                        bm_cnt[i]   <= bm_cnt[i] + 1;
                    end
                end
            end
        end
    end

    assign buf_valid = bm_valid | spur;

    always_comb begin
        buf_data = '0;
        for (int i = 0; i < NS; i++) buf_data[20*i +: 20] = bm_data[i];
    end

    always @(posedge clk) begin
        #1;
        case (rmode)
            0: inj_ready = 1'b1;
            1: inj_ready = ($urandom % 4) != 0;
            2: inj_ready = ~inj_ready;
            default: inj_ready = 1'b0;
        endcase
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Expected stream: rounds of up to Q words per source, source order 0..NS-1.
    task automatic push_expected();
        for (int r = 0; r * Q < W; r++)
            for (int s = 0; s < NS; s++)
                for (int w = r * Q; w < r * Q + Q && w < W; w++)
                    exp_q.push_back({salt, 4'(s), 8'(w)});
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            hold_v = 1'b0;
        end else begin
            check("en_onehot", 32'($countones(buf_en) <= 1), 1);
            delivered += $countones(bm_valid);
            if (busy && inj_valid && !inj_ready) stall_ref++;
            if (hold_v) begin
                check("hold_valid", inj_valid, 1);
                check("hold_data", inj_data, hold_d);
            end
            if (inj_valid && inj_ready) begin
                acc++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_extra: got %05h expected none", inj_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("sb_word", inj_data, exp_w);
                end
            end
            hold_v = inj_valid && !inj_ready;
            hold_d = inj_data;
        end
    end

    task automatic do_start();
        salt = 8'($urandom);
        push_expected();
        acc = 0;
        delivered = 0;
        stall_ref = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (all_done) break;
        end
        check("all_done", all_done, 1);
        check("queue_empty", exp_q.size(), 0);
        check("word_count", acc, NS * W);
        check("busy_done", busy, 0);
    endtask

    task automatic wait_acc(input int n);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (acc >= n) break;
        end
        check("acc_reach", 32'(acc >= n), 1);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_buf_en"}, buf_en, 0);
        check({tag, "_inj_valid"}, inj_valid, 0);
        check({tag, "_inj_data"}, inj_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_all_done"}, all_done, 0);
        check({tag, "_perr"}, protocol_err, 0);
    endtask

    int en0_run, first_en, first_v;
    logic run_on;

    initial begin
        rst = 1'b0;
        start = 1'b0;
        inj_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outs("rst");
        rst = 1'b1;

        // Run A: ready always high, startup timing, full ordered stream.
        rmode = 0;
        do_start();
        en0_run = 0; first_en = -1; first_v = -1; run_on = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (buf_en[0] && first_en < 0) first_en = c;
            if (run_on && buf_en == 4'b0001) en0_run++;
            else run_on = 1'b0;
            if (inj_valid && first_v < 0) first_v = c;
            if (c == 5) check("en_src1_prime", buf_en, 4'b0010);
        end
        check("en0_run", en0_run, 5);
        check("first_lat", first_v - first_en, 3);
        wait_done();
        check("perr_a", protocol_err, 0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("done_sticky", all_done, 1);
        check("done_nobusy", busy, 0);

        // Run B: random backpressure with a 10-cycle stall mid-run.
        do_reset();
        rmode = 1;
        do_start();
        wait_acc(50);
        @(posedge clk);
        rmode = 3;
        repeat (10) @(negedge clk);
        #1;
        check("stall_en_off", buf_en, 0);
        check("stall_buffered", delivered - acc, D);
        check("stall_valid", inj_valid, 1);
        rmode = 1;
        wait_done();
        check("perr_b", protocol_err, 0);

        // Run C: spurious word from source 2 while source 0 is granted.
        do_reset();
        rmode = 0;
        do_start();
        check("perr_pre", protocol_err, 0);
        @(posedge clk); #1 spur = 4'b0100;
        @(posedge clk); #1 spur = '0;
        @(negedge clk);
        check("perr_set", protocol_err, 1);
        wait_done();
        check("perr_sticky", protocol_err, 1);

        // Run D: reset after 37 words, then a fresh run from src0 w0.
        do_reset();
        @(negedge clk);
        check("perr_cleared", protocol_err, 0);
        rmode = 1;
        do_start();
        wait_acc(37);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_reset_outs("midrst");
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b1;
        do_start();
        wait_done();
        check("perr_d", protocol_err, 0);

        // Run E: ready low every other cycle.
        do_reset();
        rmode = 2;
        do_start();
        wait_done();
`ifdef INJ_SCHED_STATS_EN
        check("stall_cycles", stall_cycles, stall_ref);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
